algo_2r1w_b781_rdpath: RTL and testbench

Read/write datapath shim between the 2R1W b781 algorithm's user ports and its 2R1W physical memory (`t1`, ports A write, B/C read). It steers user commands onto the memory ports and aligns returned read data to the fixed memory latency. It forwards same-cycle write data into reads of the same address, giving write-through semantics, and optionally registers the outputs. Its `t1_*` and `rd_*` outputs are exactly the signals the 2r1w_b781 assertion wrapper observes.

---
 rtl/algo_2r1w_b781_pkg.sv | 26 ++
 rtl/algo_2r1w_b781_fwdpipe.sv | 62 ++++++
 rtl/algo_2r1w_b781_rdpath.sv | 107 ++++++++++
 tb/tb_algo_2r1w_b781_rdpath.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_2r1w_b781_pkg.sv
// rtl/algo_2r1w_b781_pkg.sv - shared defaults, forwarding entry type and merge helper for the b781 read path
package algo_2r1w_b781_pkg;

    localparam int DEF_WIDTH    = 15;
    localparam int DEF_BITADDR  = 8;
    localparam int DEF_NUMRDPRT = 2;
    localparam int DEF_T1_DELAY = 2;
    localparam int DEF_FLOPOUT  = 0;

    // One in-flight read: valid, which bits come from the same-cycle write, and that write's data.
    typedef struct packed {
        logic                 vld;
        logic [DEF_WIDTH-1:0] mask;
        logic [DEF_WIDTH-1:0] data;
    } fwd_ent_t;

    // Memory data where the mask is clear, forwarded write data where it is set.
    function automatic logic [DEF_WIDTH-1:0] merge(
        input logic [DEF_WIDTH-1:0] m,
        input logic [DEF_WIDTH-1:0] d,
        input logic [DEF_WIDTH-1:0] k
    );
        return (m & ~k) | (d & k);
    endfunction

endpackage

// File: rtl/algo_2r1w_b781_fwdpipe.sv
// rtl/algo_2r1w_b781_fwdpipe.sv - one read port: write-hit compare, latency-matched entry pipe, return merge
module algo_2r1w_b781_fwdpipe
    import algo_2r1w_b781_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int BITADDR  = DEF_BITADDR,
    parameter int T1_DELAY = DEF_T1_DELAY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue,
    input  logic [BITADDR-1:0] rd_adr,
    input  logic               write,
    input  logic [BITADDR-1:0] wr_adr,
    input  logic [WIDTH-1:0]   din,
    input  logic [WIDTH-1:0]   bw,
    input  logic [WIDTH-1:0]   mem_dout,
    output logic               vld,
    output logic [WIDTH-1:0]   dout
);

    // Same field layout as fwd_ent_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t ent_in;
    ent_t stage [T1_DELAY];
    ent_t ret;

    // Build the entry at issue: the memory returns pre-write data, so a same-address write is carried along.
    always_comb begin
        ent_in      = '0;
        ent_in.vld  = issue;
        ent_in.mask = (issue && write && (rd_adr == wr_adr)) ? bw : '0;
        ent_in.data = din;
    end

    // Shift entries in lockstep with the memory latency; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < T1_DELAY; i++) begin
                stage[i].vld <= 1'b0;
            end
        end else begin
            stage[0] <= ent_in;
            for (int i = 1; i < T1_DELAY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Combine returning memory data with any forwarded write bits.
    always_comb begin
        ret  = stage[T1_DELAY-1];
        vld  = ret.vld;
        dout = (mem_dout & ~ret.mask) | (ret.data & ret.mask);
    end

endmodule

// File: rtl/algo_2r1w_b781_rdpath.sv
// rtl/algo_2r1w_b781_rdpath.sv - 2R1W b781 port steering, write-through forwarding and optional output register
module algo_2r1w_b781_rdpath
    import algo_2r1w_b781_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int BITADDR  = DEF_BITADDR,
    parameter int NUMRDPRT = DEF_NUMRDPRT,
    parameter int T1_DELAY = DEF_T1_DELAY,
    parameter int FLOPOUT  = DEF_FLOPOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flopout_en,
    input  logic [NUMRDPRT-1:0]         read,
    input  logic [NUMRDPRT*BITADDR-1:0] rd_adr,
    input  logic                        write,
    input  logic [BITADDR-1:0]          wr_adr,
    input  logic [WIDTH-1:0]            din,
    input  logic [WIDTH-1:0]            bw,
    output logic                        t1_readB,
    output logic [BITADDR-1:0]          t1_addrB,
    input  logic [WIDTH-1:0]            t1_doutB,
    output logic                        t1_readC,
    output logic [BITADDR-1:0]          t1_addrC,
    input  logic [WIDTH-1:0]            t1_doutC,
    output logic                        t1_writeA,
    output logic [BITADDR-1:0]          t1_addrA,
    output logic [WIDTH-1:0]            t1_dinA,
    output logic [WIDTH-1:0]            t1_bwA,
    output logic [NUMRDPRT*WIDTH-1:0]   rd_dout,
    output logic [NUMRDPRT-1:0]         rd_vld
);

    logic [NUMRDPRT-1:0]       pipe_vld;
    logic [WIDTH-1:0]          pipe_dout [NUMRDPRT];
    logic [NUMRDPRT-1:0]       comb_vld;
    logic [NUMRDPRT*WIDTH-1:0] comb_dout;
    logic [NUMRDPRT-1:0]       flop_vld;
    logic [NUMRDPRT*WIDTH-1:0] flop_dout;

    // Steer port 0 to B, port 1 to C, the write to A; strobes are held off while in reset.
    always_comb begin
        t1_readB  = read[0] & rst;
        t1_addrB  = rd_adr[0 +: BITADDR];
        t1_readC  = read[1] & rst;
        t1_addrC  = rd_adr[BITADDR +: BITADDR];
        t1_writeA = write & rst;
        t1_addrA  = wr_adr;
        t1_dinA   = din;
        t1_bwA    = bw;
    end

    for (genvar p = 0; p < NUMRDPRT; p++) begin : g_port
        algo_2r1w_b781_fwdpipe #(
            .WIDTH    (WIDTH),
            .BITADDR  (BITADDR),
            .T1_DELAY (T1_DELAY)
        ) u_fwdpipe (
            .clk      (clk),
            .rst      (rst),
            .issue    (read[p] & rst),
            .rd_adr   (rd_adr[p*BITADDR +: BITADDR]),
            .write    (t1_writeA),
            .wr_adr   (wr_adr),
            .din      (din),
            .bw       (bw),
            .mem_dout ((p == 0) ? t1_doutB : t1_doutC),
            .vld      (pipe_vld[p]),
            .dout     (pipe_dout[p])
        );
    end

    // Unregistered result: data is zeroed on ports without a valid return.
    always_comb begin
        comb_vld  = '0;
        comb_dout = '0;
        for (int p = 0; p < NUMRDPRT; p++) begin
            comb_vld[p] = pipe_vld[p] & rst;
            if (comb_vld[p]) begin
                comb_dout[p*WIDTH +: WIDTH] = pipe_dout[p];
            end
        end
    end

    // Optional output stage: loads only when enabled, otherwise holds and the returning entry is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flop_vld  <= '0;
            flop_dout <= '0;
        end else if (flopout_en) begin
            flop_vld  <= comb_vld;
            flop_dout <= comb_dout;
        end
    end

    // Select the registered or direct result; outputs read as zero while in reset.
    always_comb begin
        if (FLOPOUT != 0) begin
            rd_vld  = rst ? flop_vld  : '0;
            rd_dout = rst ? flop_dout : '0;
        end else begin
            rd_vld  = comb_vld;
            rd_dout = comb_dout;
        end
    end

endmodule

// File: tb/tb_algo_2r1w_b781_rdpath.sv
// tb/tb_algo_2r1w_b781_rdpath.sv - self-checking bench for the b781 read path, FLOPOUT=0 and FLOPOUT=1 instances
module tb_algo_2r1w_b781_rdpath;

    localparam int W = 15;
    localparam int A = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flopout_en, write;
    logic [1:0]     read;
    logic [2*A-1:0] rd_adr;
    logic [A-1:0]   wr_adr;
    logic [W-1:0]   din, bw;
    logic [W-1:0]   doutB, doutC;

    logic           r0B, r0C, w0A, r1B, r1C, w1A;
    logic [A-1:0]   a0B, a0C, a0A, a1B, a1C, a1A;
    logic [W-1:0]   d0A, b0A, d1A, b1A;
    logic [2*W-1:0] rdd0, rdd1;
    logic [1:0]     rdv0, rdv1;

    algo_2r1w_b781_rdpath #(.WIDTH(W), .BITADDR(A), .NUMRDPRT(2), .T1_DELAY(D), .FLOPOUT(0)) dut0 (
        .clk(clk), .rst(rst), .flopout_en(flopout_en), .read(read), .rd_adr(rd_adr),
        .write(write), .wr_adr(wr_adr), .din(din), .bw(bw),
        .t1_readB(r0B), .t1_addrB(a0B), .t1_doutB(doutB),
        .t1_readC(r0C), .t1_addrC(a0C), .t1_doutC(doutC),
        .t1_writeA(w0A), .t1_addrA(a0A), .t1_dinA(d0A), .t1_bwA(b0A),
        .rd_dout(rdd0), .rd_vld(rdv0)
    );

    algo_2r1w_b781_rdpath #(.WIDTH(W), .BITADDR(A), .NUMRDPRT(2), .T1_DELAY(D), .FLOPOUT(1)) dut1 (
        .clk(clk), .rst(rst), .flopout_en(flopout_en), .read(read), .rd_adr(rd_adr),
        .write(write), .wr_adr(wr_adr), .din(din), .bw(bw),
        .t1_readB(r1B), .t1_addrB(a1B), .t1_doutB(doutB),
        .t1_readC(r1C), .t1_addrC(a1C), .t1_doutC(doutC),
        .t1_writeA(w1A), .t1_addrA(a1A), .t1_dinA(d1A), .t1_bwA(b1A),
        .rd_dout(rdd1), .rd_vld(rdv1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Physical memory: read data appears D cycles later and reflects contents before this cycle's write.
    logic [W-1:0] phy_mem [256];
    logic [W-1:0] pb [D];
    logic [W-1:0] pc [D];
    assign doutB = pb[D-1];
    assign doutC = pc[D-1];

    always @(posedge clk) begin
        pb[0] <= r0B ? phy_mem[a0B] : W'($urandom);
        pc[0] <= r0C ? phy_mem[a0C] : W'($urandom);
        for (int i = 1; i < D; i++) begin
            pb[i] <= pb[i-1];
            pc[i] <= pc[i-1];
        end
        if (w0A) phy_mem[a0A] <= (phy_mem[a0A] & ~b0A) | (d0A & b0A);
    end

    // Reference: a read returns the address contents after this cycle's write (write-through),
    // scheduled to appear D cycles later; reset cancels all pending results.
    logic [W-1:0]   ref_mem [256];
    bit             s_vld [2][8];
    logic [W-1:0]   s_dat [2][8];
    int             cyc = 0;
    logic [1:0]     f_vld;
    logic [2*W-1:0] f_dat;

    function automatic void exp_direct(output logic [1:0] v, output logic [2*W-1:0] d);
        v = '0;
        d = '0;
        for (int p = 0; p < 2; p++) begin
            if (rst && s_vld[p][cyc % 8]) begin
                v[p] = 1'b1;
                d[p*W +: W] = s_dat[p][cyc % 8];
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [1:0]     ev;
        logic [2*W-1:0] ed;
        exp_direct(ev, ed);
        if (!rst) begin
            f_vld = '0;
            f_dat = '0;
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < 8; s++) s_vld[p][s] = 1'b0;
        end else begin
            if (flopout_en) begin
                f_vld = ev;
                f_dat = ed;
            end
            for (int p = 0; p < 2; p++) s_vld[p][cyc % 8] = 1'b0;
            if (write) ref_mem[wr_adr] = (ref_mem[wr_adr] & ~bw) | (din & bw);
            for (int p = 0; p < 2; p++) begin
                if (read[p]) begin
                    s_vld[p][(cyc + D) % 8] = 1'b1;
                    s_dat[p][(cyc + D) % 8] = ref_mem[rd_adr[p*A +: A]];
                end
            end
        end
        cyc++;
    end

    // Every cycle: steering of both instances and read results against the reference.
    always @(negedge clk) begin
        logic [1:0]     ev;
        logic [2*W-1:0] ed;
        if (cyc > 0) begin
            exp_direct(ev, ed);
            check("rd_vld0",  rdv0, ev);
            check("rd_dout0", rdd0, ed);
            check("rd_vld1",  rdv1, rst ? f_vld : 2'b00);
            check("rd_dout1", rdd1, rst ? f_dat : '0);
            check("readB0",  r0B, read[0] & rst);
            check("readC0",  r0C, read[1] & rst);
            check("writeA0", w0A, write & rst);
            check("addrB0",  a0B, rd_adr[A-1:0]);
            check("addrC0",  a0C, rd_adr[2*A-1:A]);
            check("addrA0",  a0A, wr_adr);
            check("dinA0",   d0A, din);
            check("bwA0",    b0A, bw);
            check("readB1",  r1B, read[0] & rst);
            check("readC1",  r1C, read[1] & rst);
            check("writeA1", w1A, write & rst);
            check("addrB1",  a1B, rd_adr[A-1:0]);
            check("addrC1",  a1C, rd_adr[2*A-1:A]);
            check("addrA1",  a1A, wr_adr);
            check("dinA1",   d1A, din);
            check("bwA1",    b1A, bw);
        end
    end

    task automatic drive(input logic r, input logic [1:0] rd, input logic [A-1:0] ra0, input logic [A-1:0] ra1,
                         input logic wr, input logic [A-1:0] wa, input logic [W-1:0] d, input logic [W-1:0] b,
                         input logic en);
        @(posedge clk);
        #1;
        rst = r; read = rd; rd_adr = {ra1, ra0}; write = wr; wr_adr = wa; din = d; bw = b; flopout_en = en;
    endtask

    task automatic idle(input logic en);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, en);
    endtask

    initial begin
        rst = 1'b0; read = '0; rd_adr = '0; write = 1'b0; wr_adr = '0; din = '0; bw = '0; flopout_en = 1'b1;

        // Reset with requests present: everything must stay quiet.
        repeat (3) begin
            drive(1'b0, 2'b11, 8'h10, 8'h20, 1'b1, 8'h10, 15'h7FFF, 15'h7FFF, 1'b1);
            @(negedge clk);
            check("rst_readB",  r0B, 0);
            check("rst_readC",  r0C, 0);
            check("rst_writeA", w0A, 0);
            check("rst_vld0",   rdv0, 0);
            check("rst_dout0",  rdd0, 0);
            check("rst_vld1",   rdv1, 0);
            check("rst_dout1",  rdd1, 0);
        end
        idle(1'b1);

        // Preload.
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h10, 15'h1234, 15'h7FFF, 1'b1);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h20, 15'h7FFF, 15'h7FFF, 1'b1);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h30, 15'h5555, 15'h7FFF, 1'b1);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h40, 15'h2AAA, 15'h7FFF, 1'b1);
        idle(1'b1);

        // Basic read on port 0.
        drive(1'b1, 2'b01, 8'h10, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        idle(1'b1); @(negedge clk);
        check("basic_early_vld", rdv0, 2'b00);
        idle(1'b1); @(negedge clk);
        check("basic_vld",  rdv0, 2'b01);
        check("basic_dout", rdd0[W-1:0], 15'h1234);
        idle(1'b1); @(negedge clk);
        check("basic_late_vld", rdv0, 2'b00);
        check("basic_flop_vld", rdv1, 2'b01);
        check("basic_flop_dout", rdd1[W-1:0], 15'h1234);

        // Forwarding: both ports hit a partial write; next-cycle read sees memory.
        drive(1'b1, 2'b11, 8'h20, 8'h20, 1'b1, 8'h20, 15'h0000, 15'h00FF, 1'b1);
        drive(1'b1, 2'b01, 8'h20, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        idle(1'b1); @(negedge clk);
        check("fwd_vld",  rdv0, 2'b11);
        check("fwd_dout", rdd0, {15'h7F00, 15'h7F00});
        idle(1'b1); @(negedge clk);
        check("fwd_mem_vld",  rdv0, 2'b01);
        check("fwd_mem_dout", rdd0[W-1:0], 15'h7F00);

        // A read one cycle before a write keeps the old value.
        drive(1'b1, 2'b01, 8'h30, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h30, 15'h0001, 15'h7FFF, 1'b1);
        idle(1'b1); @(negedge clk);
        check("stale_vld",  rdv0, 2'b01);
        check("stale_dout", rdd0[W-1:0], 15'h5555);
        idle(1'b1);

        // Output register: second result is dropped by a disabled load, first one held.
        drive(1'b1, 2'b10, 8'h00, 8'h10, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        drive(1'b1, 2'b10, 8'h00, 8'h30, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        idle(1'b1);
        idle(1'b0); @(negedge clk);
        check("flop_t3_vld",  rdv1, 2'b10);
        check("flop_t3_dout", rdd1[2*W-1:W], 15'h1234);
        check("flop_direct_dout", rdd0[2*W-1:W], 15'h0001);
        idle(1'b1); @(negedge clk);
        check("flop_hold_vld",  rdv1, 2'b10);
        check("flop_hold_dout", rdd1[2*W-1:W], 15'h1234);
        idle(1'b1); @(negedge clk);
        check("flop_drop_vld", rdv1, 2'b00);

        // Reset mid-flight with ignored requests during the reset cycle.
        drive(1'b1, 2'b01, 8'h10, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        drive(1'b0, 2'b11, 8'h20, 8'h20, 1'b1, 8'h20, 15'h1111, 15'h7FFF, 1'b1);
        drive(1'b1, 2'b01, 8'h20, 8'h00, 1'b0, 8'h00, 15'h0000, 15'h0000, 1'b1);
        @(negedge clk);
        check("midrst_lost_vld", rdv0, 2'b00);
        idle(1'b1); @(negedge clk);
        check("midrst_ign_vld", rdv0, 2'b00);
        idle(1'b1); @(negedge clk);
        check("midrst_fresh_vld",  rdv0, 2'b01);
        check("midrst_fresh_dout", rdd0[W-1:0], 15'h7F00);

        // Mixed traffic on a few preloaded addresses, with occasional reset cycles.
        repeat (80) begin
            drive(1'b1 ^ ($urandom_range(0, 15) == 0), 2'($urandom),
                  {4'($urandom_range(1, 4)), 4'h0}, {4'($urandom_range(1, 4)), 4'h0},
                  1'($urandom), {4'($urandom_range(1, 4)), 4'h0}, W'($urandom), W'($urandom),
                  1'($urandom));
        end
        repeat (5) idle(1'b1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
